// File: rtl/load_store_unit_if.sv
// Data-memory request/grant/response port between the load/store unit (master)
// and the data memory (slave). Word addressed; byte lanes selected by mem_be.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: lane steering, byte enables and load extension over a
// req/gnt/rvalid port. Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses.
module load_store_unit (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  input  logic                    ex_we,
  input  logic [2:0]              ex_funct3,
  input  logic [31:0]             ex_addr,
  input  logic [31:0]             ex_wdata,
  output logic                    lsu_busy,
  output logic                    done,
  output logic                    rd_valid,
  output logic [31:0]             rd_data,
  output logic                    err,
  load_store_unit_if.master       mem
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]  state;
  logic        op_we;
  logic [2:0]  op_funct3;
  logic [1:0]  op_off;

  logic        funct3_ok;
  logic        accept_ok;
  logic [1:0]  eff_off;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] shifted;
  logic [31:0] load_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  // Request decode; eff_off is the byte offset after forcing natural alignment
  always_comb begin
    if (ex_we)
      funct3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
    else
      funct3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                  (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                 ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
    accept_ok  = funct3_ok && !misaligned;
`else
    accept_ok  = funct3_ok;
`endif
    case (ex_funct3[1:0])
      2'b00:   eff_off = ex_addr[1:0];
      2'b01:   eff_off = {ex_addr[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
    case (ex_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << eff_off;
        st_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = eff_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
      end
    endcase
  end

  always_comb begin
    shifted = mem.mem_rdata >> {op_off, 3'b000};
    case (op_funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Access sequencer; the memory port fields stay frozen from accept until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op_we         <= 1'b0;
      op_funct3     <= 3'b000;
      op_off        <= 2'b00;
      lsu_busy      <= 1'b0;
      done          <= 1'b0;
      rd_valid      <= 1'b0;
      err           <= 1'b0;
      rd_data       <= 32'h0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_be    <= 4'b0000;
      mem.mem_addr  <= 32'h0;
      mem.mem_wdata <= 32'h0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (accept_ok) begin
              state         <= ST_REQ;
              lsu_busy      <= 1'b1;
              op_we         <= ex_we;
              op_funct3     <= ex_funct3;
              op_off        <= eff_off;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= ex_we;
              mem.mem_be    <= ex_we ? st_be : 4'b1111;
              mem.mem_addr  <= {ex_addr[31:2], 2'b00};
              mem.mem_wdata <= ex_we ? st_wdata : 32'h0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_gnt) begin
            mem.mem_req <= 1'b0;
            if (op_we) begin
              state    <= ST_IDLE;
              lsu_busy <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem.mem_rvalid) begin
            state    <= ST_IDLE;
            lsu_busy <= 1'b0;
            done     <= 1'b1;
            rd_valid <= 1'b1;
            rd_data  <= load_data;
          end
        end
        default: begin
          state       <= ST_IDLE;
          lsu_busy    <= 1'b0;
          mem.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec cases plus randomized
// accesses with random grant/response delays, checked against an arithmetic model.
module tb_load_store_unit;

  typedef struct packed {
    int          req_cycles;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        stable;
    int          done_k;
    int          done_cnt;
    int          rdv_k;
    int          rdv_cnt;
    int          err_k;
    int          err_cnt;
    int          busy_cnt;
    logic [31:0] rd_cap;
    logic [31:0] rd_end;
  } obs_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_val;
  } dir_t;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_we;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        lsu_busy;
  logic        done;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        err;

  int total = 0;
  int bad   = 0;

  load_store_unit_if mem_bus ();

  load_store_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_we     (ex_we),
    .ex_funct3 (ex_funct3),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .lsu_busy  (lsu_busy),
    .done      (done),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .err       (err),
    .mem       (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected legality, memory request fields and load result
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rdat,
                                output logic legal, output logic [3:0] be,
                                output logic [31:0] maddr, output logic [31:0] mwd,
                                output logic [31:0] rd);
    int unsigned size, off;
    logic [31:0] v;
    size = 32'(f3) % 4;
    off  = a % 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((size == 1 && a % 2 == 1) || (size == 2 && off != 0)) legal = 1'b0;
`endif
    if (size == 1) off = off - off % 2;
    else if (size == 2) off = 0;
    maddr = a - a % 4;
    rd = 32'h0;
    mwd = 32'h0;
    be = 4'hF;
    if (we) begin
      if (size == 0) begin be = 4'(1 << off); mwd = (wd % 256) * 32'h01010101; end
      else if (size == 1) begin be = 4'(3 << off); mwd = (wd % 65536) * 32'h00010001; end
      else mwd = wd;
    end else begin
      v = rdat >> (8 * off);
      case (f3)
        3'd0: rd = (v % 256 >= 128) ? v % 256 - 32'd256 : v % 256;
        3'd1: rd = (v % 65536 >= 32768) ? v % 65536 - 32'd65536 : v % 65536;
        3'd4: rd = v % 256;
        3'd5: rd = v % 65536;
        default: rd = rdat;
      endcase
    end
  endfunction

  // Issue one op and play the memory: grant after gd waiting cycles, data rd cycles after gnt
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdat,
                       input int gd, input int rd, output obs_t o);
    logic granted;
    int gk;
    int n;
    o = '0;
    o.stable = 1'b1;
    granted = 1'b0;
    gk = 0;
    n = gd + rd + 6;
    @(negedge clk);
    ex_valid = 1'b1; ex_we = we; ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ex_valid = 1'b0; ex_addr = $urandom; ex_wdata = $urandom; ex_funct3 = 3'($urandom);
      end
      if (mem_bus.mem_req) begin
        if (o.req_cycles == 0) begin
          o.cap_we = mem_bus.mem_we; o.cap_be = mem_bus.mem_be;
          o.cap_addr = mem_bus.mem_addr; o.cap_wdata = mem_bus.mem_wdata;
        end else if (o.cap_we !== mem_bus.mem_we || o.cap_be !== mem_bus.mem_be ||
                     o.cap_addr !== mem_bus.mem_addr || o.cap_wdata !== mem_bus.mem_wdata)
          o.stable = 1'b0;
        o.req_cycles++;
      end
      if (done) begin o.done_cnt++; if (o.done_k == 0) o.done_k = k; end
      if (rd_valid) begin o.rdv_cnt++; o.rdv_k = k; o.rd_cap = rd_data; end
      if (err) begin o.err_cnt++; o.err_k = k; end
      if (lsu_busy) o.busy_cnt++;
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = $urandom;
      if (mem_bus.mem_req && !granted && o.req_cycles > gd) begin
        mem_bus.mem_gnt = 1'b1; granted = 1'b1; gk = k;
      end else if (mem_bus.mem_req && !granted) begin
        mem_bus.mem_rvalid = 1'b1;
      end
      if (granted && k == gk + 1 + rd) begin
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = rdat;
      end
    end
    o.rd_end = rd_data;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({lsu_busy, done, rd_valid, err, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be,
         mem_bus.mem_addr, mem_bus.mem_wdata, rd_data} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b rdv=%b err=%b req=%b we=%b be=%h addr=%h wdata=%h rd=%h, want all 0",
               lsu_busy, done, rd_valid, err, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be,
               mem_bus.mem_addr, mem_bus.mem_wdata, rd_data);
    end
  endtask

  task automatic test_directed();
    dir_t tbl [6];
    obs_t o;
    tbl[0] = '{1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 4'b1111, 32'h104, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 4'b1000, 32'h100, 32'hA5A5A5A5};
    tbl[2] = '{1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 4'b1100, 32'h100, 32'hBEEFBEEF};
    tbl[3] = '{1'b0, 3'b000, 32'h101, 32'h0, 32'h00008000, 4'b1111, 32'h100, 32'hFFFFFF80};
    tbl[4] = '{1'b0, 3'b100, 32'h101, 32'h0, 32'h00008000, 4'b1111, 32'h100, 32'h00000080};
    tbl[5] = '{1'b0, 3'b101, 32'h102, 32'h0, 32'hBEEF0000, 4'b1111, 32'h100, 32'h0000BEEF};
    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, 0, 0, o);
      total++;
      if (o.cap_be !== tbl[i].exp_be || o.cap_addr !== tbl[i].exp_addr || o.cap_we !== tbl[i].we) begin
        bad++;
        $display("[TB] FAIL dir%0d req_fields: be=%b addr=%h we=%b want be=%b addr=%h we=%b", i,
                 o.cap_be, o.cap_addr, o.cap_we, tbl[i].exp_be, tbl[i].exp_addr, tbl[i].we);
      end
      total++;
      if (o.done_k !== (tbl[i].we ? 2 : 3) || o.done_cnt !== 1) begin
        bad++;
        $display("[TB] FAIL dir%0d done_timing: at=%0d count=%0d want at=%0d count=1", i,
                 o.done_k, o.done_cnt, tbl[i].we ? 2 : 3);
      end
      total++;
      if (tbl[i].we && o.cap_wdata !== tbl[i].exp_val) begin
        bad++;
        $display("[TB] FAIL dir%0d wdata: got %h want %h", i, o.cap_wdata, tbl[i].exp_val);
      end else if (!tbl[i].we && (o.rd_cap !== tbl[i].exp_val || o.rdv_cnt !== 1)) begin
        bad++;
        $display("[TB] FAIL dir%0d rd_data: got %h (rdv %0d) want %h (rdv 1)", i, o.rd_cap,
                 o.rdv_cnt, tbl[i].exp_val);
      end
    end
  endtask

  task automatic test_delayed_load();
    obs_t o;
    do_op(1'b0, 3'b010, 32'h0000_0A40, 32'h0, 32'h1357_9BDF, 3, 1, o);
    total++;
    if (o.req_cycles !== 4 || o.stable !== 1'b1) begin
      bad++;
      $display("[TB] FAIL delayed mem_req_hold: cycles=%0d stable=%b want 4 1", o.req_cycles, o.stable);
    end
    total++;
    if (o.rdv_k !== 7 || o.rdv_cnt !== 1 || o.busy_cnt !== 6) begin
      bad++;
      $display("[TB] FAIL delayed rd_valid: at=%0d count=%0d busy=%0d want 7 1 6", o.rdv_k,
               o.rdv_cnt, o.busy_cnt);
    end
    total++;
    if (o.rd_cap !== 32'h1357_9BDF || o.rd_end !== 32'h1357_9BDF) begin
      bad++;
      $display("[TB] FAIL delayed rd_hold: got %h/%h want 13579bdf", o.rd_cap, o.rd_end);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    do_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h1122_3344, 0, 0, o);
`ifdef LSU_MISALIGN_TRAP_EN
    total++;
    if (o.err_cnt !== 1 || o.err_k !== 1 || o.req_cycles !== 0 || o.done_cnt !== 0) begin
      bad++;
      $display("[TB] FAIL misalign_trap: err=%0d@%0d req=%0d done=%0d want 1@1 0 0", o.err_cnt,
               o.err_k, o.req_cycles, o.done_cnt);
    end
`else
    total++;
    if (o.err_cnt !== 0 || o.cap_addr !== 32'h100 || o.rd_cap !== 32'h1122_3344) begin
      bad++;
      $display("[TB] FAIL misalign_align: err=%0d addr=%h rd=%h want 0 100 11223344", o.err_cnt,
               o.cap_addr, o.rd_cap);
    end
`endif
  endtask

  task automatic test_illegal();
    obs_t o;
    logic [3:0] codes [5];
    codes[0] = 4'b0011; codes[1] = 4'b0110; codes[2] = 4'b0111;
    codes[3] = 4'b1011; codes[4] = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      do_op(codes[i][3], codes[i][2:0], $urandom, $urandom, $urandom, 0, 0, o);
      total++;
      if (o.err_cnt !== 1 || o.err_k !== 1 || o.req_cycles !== 0 || o.done_cnt !== 0 ||
          o.busy_cnt !== 0) begin
        bad++;
        $display("[TB] FAIL illegal we=%b f3=%b: err=%0d@%0d req=%0d done=%0d busy=%0d", codes[i][3],
                 codes[i][2:0], o.err_cnt, o.err_k, o.req_cycles, o.done_cnt, o.busy_cnt);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic we, legal;
    logic [2:0] f3;
    logic [31:0] a, wd, rdat, maddr, mwd, rdexp;
    logic [3:0] be;
    int gd, rd, dk;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); f3 = 3'($urandom_range(0, 7)); a = $urandom; wd = $urandom;
      rdat = $urandom; gd = $urandom_range(0, 3); rd = $urandom_range(0, 2);
      model(we, f3, a, wd, rdat, legal, be, maddr, mwd, rdexp);
      do_op(we, f3, a, wd, rdat, gd, rd, o);
      if (!legal) begin
        total++;
        if (o.err_cnt !== 1 || o.req_cycles !== 0 || o.done_cnt !== 0) begin
          bad++;
          $display("[TB] FAIL rnd%0d reject: err=%0d req=%0d done=%0d want 1 0 0", i, o.err_cnt,
                   o.req_cycles, o.done_cnt);
        end
      end else begin
        dk = we ? gd + 2 : gd + 3 + rd;
        total++;
        if (o.err_cnt !== 0 || o.req_cycles !== gd + 1 || o.stable !== 1'b1) begin
          bad++;
          $display("[TB] FAIL rnd%0d request: err=%0d req=%0d stable=%b want 0 %0d 1", i,
                   o.err_cnt, o.req_cycles, o.stable, gd + 1);
        end
        total++;
        if (o.cap_we !== we || o.cap_be !== be || o.cap_addr !== maddr ||
            (we && o.cap_wdata !== mwd)) begin
          bad++;
          $display("[TB] FAIL rnd%0d fields: we=%b be=%b addr=%h wd=%h want %b %b %h %h", i,
                   o.cap_we, o.cap_be, o.cap_addr, o.cap_wdata, we, be, maddr, mwd);
        end
        total++;
        if (o.done_k !== dk || o.done_cnt !== 1 || o.busy_cnt !== dk - 1) begin
          bad++;
          $display("[TB] FAIL rnd%0d timing: done@%0d x%0d busy=%0d want @%0d x1 busy=%0d", i,
                   o.done_k, o.done_cnt, o.busy_cnt, dk, dk - 1);
        end
        total++;
        if (we ? (o.rdv_cnt !== 0)
               : (o.rdv_cnt !== 1 || o.rdv_k !== dk || o.rd_cap !== rdexp || o.rd_end !== rdexp)) begin
          bad++;
          $display("[TB] FAIL rnd%0d load: rdv=%0d@%0d rd=%h end=%h want %0d@%0d %h", i, o.rdv_cnt,
                   o.rdv_k, o.rd_cap, o.rd_end, we ? 0 : 1, dk, rdexp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic req_exp [5];
    logic done_exp [5];
    req_exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    done_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    ex_valid = 1'b1; ex_we = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h300; ex_wdata = 32'hCAFEF00D;
    mem_bus.mem_gnt = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++;
      if (mem_bus.mem_req !== req_exp[k-1] || done !== done_exp[k-1]) begin
        bad++;
        $display("[TB] FAIL b2b cycle%0d: req=%b done=%b want %b %b", k, mem_bus.mem_req, done,
                 req_exp[k-1], done_exp[k-1]);
      end
      if (k == 3) ex_valid = 1'b0;
    end
    mem_bus.mem_gnt = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h200;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    mem_bus.mem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    total++;
    if (lsu_busy !== 1'b1 || mem_bus.mem_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wait_state: busy=%b req=%b want 1 0", lsu_busy, mem_bus.mem_req);
    end
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (rd_valid !== 1'b0 || done !== 1'b0 || rd_data !== 32'h0 || lsu_busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stale_rvalid: rdv=%b done=%b rd=%h busy=%b want 0 0 0 0", rd_valid,
                 done, rd_data, lsu_busy);
      end
    end
    mem_bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_we = 1'b0; ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    $display("[TB] reset released");
    test_directed();
    test_delayed_load();
    test_misalign();
    test_illegal();
    test_random();
    test_back_to_back();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
